// File: rtl/bitrev_reorder_buffer.sv
// Ping-pong buffer that turns a bit-reversed FFT output frame into natural order.
// One bank fills while the other drains, so both sides can move a sample per cycle.
module bitrev_reorder_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              frame_err
);

    localparam int N = 1 << ADDR_W;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    bank_state_t       state_q [2];
    bank_state_t       state_d [2];
    logic              wsel;
    logic              rsel;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic              wr_at_end;
    logic              rd_at_end;
    logic              wr_done;
    logic              rd_done;
    logic [DATA_W-1:0] mem [2][N];

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        r = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

    assign in_ready  = (state_q[wsel] == EMPTY);
    assign out_valid = (state_q[rsel] == FULL);
    assign out_index = rd_cnt;
    assign out_last  = &rd_cnt;
    assign out_data  = mem[rsel][rd_cnt];

    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign wr_at_end = &wr_cnt;
    assign rd_at_end = &rd_cnt;
    assign wr_done   = wr_fire && wr_at_end;
    assign rd_done   = rd_fire && rd_at_end;
    assign wr_addr   = bitrev(wr_cnt);

    // Storage is deliberately left unreset; only the flags gate visibility.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wsel][wr_addr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // The writer never owns a FULL bank and the reader never an EMPTY one,
    // so both completions in one cycle always touch different banks.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            unique case (state_q[b])
                EMPTY: begin
                    if (wr_done && wsel == 1'(b)) begin
                        state_d[b] = FULL;
                    end
                end
                FULL: begin
                    if (rd_done && rsel == 1'(b)) begin
                        state_d[b] = EMPTY;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wsel   <= 1'b0;
            wr_cnt <= '0;
        end else if (wr_fire) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_at_end) begin
                wsel <= ~wsel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsel   <= 1'b0;
            rd_cnt <= '0;
        end else if (rd_fire) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_at_end) begin
                rsel <= ~rsel;
            end
        end
    end

    // in_last is advisory: the counter alone defines the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= wr_fire && (in_last != wr_at_end);
        end
    end

endmodule

// File: doc/bitrev_reorder_buffer.md
# bitrev_reorder_buffer

Ping-pong reorder buffer on the FFT output path. It accepts one frame of N complex samples in bit-reversed index order, as produced by the FFT core, and emits the frame in natural order (index 0..N-1). Both sides use valid/ready handshakes. Two banks let frame k+1 be written while frame k is read, so sustained throughput is one sample per cycle.

## Interface
- DATA_W, 32, sample width (packed {re[15:0], im[15:0]})
- ADDR_W, 6, log2 of frame length; N = 2^ADDR_W = 64
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  in_data valid
- in_ready  output  1  buffer can accept a sample this cycle
- in_data  input  DATA_W  sample, arriving in bit-reversed order
- in_last  input  1  marks the final sample of an input frame
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  DATA_W  sample in natural order
- out_index  output  ADDR_W  natural index of out_data
- out_last  output  1  high with index N-1
- frame_err  output  1  one-cycle pulse on an in_last mismatch

## Operation
- Storage is 2 banks × N × DATA_W registers. Contents are not reset.
- Per-bank full flag. wsel and rsel are 1-bit bank selectors. wr_cnt and rd_cnt are ADDR_W-bit counters.
- **Write side:**
  - in_ready = !full[wsel].
  - On accept (in_valid && in_ready): mem[wsel][bitrev(wr_cnt)] <= in_data, then wr_cnt++.
  - bitrev mirrors bit i to bit ADDR_W-1-i. Example: wr_cnt 1 (000001) writes address 32 (100000).
  - On accept with wr_cnt == N-1: set full[wsel], toggle wsel, wrap wr_cnt to 0.
- **in_last check (on accept):**
  - in_last=1 with wr_cnt != N-1, or in_last=0 with wr_cnt == N-1, pulses frame_err for the next cycle.
  - The frame boundary is set by the counter only. There is no resync.
- **Read side:**
  - out_valid = full[rsel].
  - out_data = mem[rsel][rd_cnt]; out_index = rd_cnt; out_last = (rd_cnt == N-1).
  - On transfer (out_valid && out_ready): rd_cnt++.
  - On transfer at N-1: clear full[rsel], toggle rsel, wrap rd_cnt to 0.
- **Bank states:** each bank is EMPTY (writable) or FULL (readable).
  - EMPTY→FULL happens only on the write of index N-1.
  - FULL→EMPTY happens only on the read of index N-1.
- **Both banks FULL:** in_ready=0 and input stalls until a read frame completes.
- **Simultaneous events:** completing a write frame and a read frame in the same cycle on different banks are handled independently. Both flag updates take effect.
- **Reset (rst=1):**
  - Clears full[1:0], wsel, rsel, wr_cnt, rd_cnt and frame_err.
  - Outputs after reset: in_ready=1, out_valid=0, out_index=0, out_last=0, frame_err=0.
  - out_data is undefined while out_valid=0.
  - A partial frame present at reset is discarded, including mid-frame on either side.

## Timing
- in_ready, out_valid, out_index and out_last are derived from registers only. There is no combinational path from in_valid or out_ready.
- out_data is a combinational mux of registered storage.
- **Latency:** last input sample accepted at cycle t → out_valid=1 with index 0 at cycle t+1.
- **Stall:** while out_valid && !out_ready, out_data, out_index and out_last are held stable.
- **Throughput:** with out_ready held high and input continuous, in_ready never deasserts after the first frame. Both sides move one sample per cycle.
- **Bank release:** the freed bank is writable the cycle after its N-1 read. in_ready rises on that cycle if the writer was stalled.

## Test plan
- **Single frame:** after rst, send 64 samples where sample k carries value bitrev6(k) and in_last is on k=63. Expect out_data = 0,1,...,63 in order; out_valid first at t+1; out_last only at index 63; frame_err never.
- **Back-to-back:** send 4 frames continuously with out_ready=1. Expect in_ready constantly 1 after the first reset cycle, outputs in natural order with no bubbles, and wsel/rsel alternating.
- **Backpressure:** hold out_ready=0 and send 3 frames. Expect in_ready=0 after 128 accepted samples. Pulse out_ready randomly; expect data held stable during stalls and, after the 64th read, in_ready=1 on the next cycle.
- **in_last errors:**
  - in_last at k=10: expect a frame_err pulse, and the frame still completes at k=63.
  - in_last absent at k=63: expect a frame_err pulse.
- **Reset mid-operation:** rst after 20 input samples and during an output read at index 30. Expect out_valid=0 and in_ready=1 the next cycle, and that a fresh frame then reorders correctly with no stale data emitted.
- **Simultaneous completion:** align the write of index 63 into bank 1 with the read of index 63 from bank 0. Expect full[0]=0 and full[1]=1 next cycle, and out_valid to remain 1 with index 0 of bank 1.
